// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Dynamic branch predictor for the pipelined RV32 core.
//                A direct-mapped BTB with 2-bit saturating counters predicts
//                the next fetch PC in IF. Conditional branches resolved in EX
//                train the table and raise mispredict with the corrected PC.
//                Optional macro BRANCH_PREDICTOR_PERF_EN builds the resolved
//                and mispredicted branch counters (tied to zero otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  output logic        pred_taken,
  output logic [31:0] npc_pred,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [31:0] ex_pc,
  input  logic        ex_br,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_npc,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  localparam int c_ENTRIES = 1 << IDX_W;
  localparam int c_TAG_W   = 30 - IDX_W;

  // Table storage
  logic [c_ENTRIES-1:0] valid_q;
  logic [c_TAG_W-1:0]   tag_q    [c_ENTRIES];
  logic [31:0]          target_q [c_ENTRIES];
  logic [1:0]           ctr_q    [c_ENTRIES];

  logic [IDX_W-1:0]   w_if_idx;
  logic [c_TAG_W-1:0] w_if_tag;
  logic               w_if_hit;
  logic [31:0]        w_if_seq;

  logic [IDX_W-1:0]   w_ex_idx;
  logic [c_TAG_W-1:0] w_ex_tag;
  logic               w_ex_hit;
  logic               w_upd;
  logic               w_write;
  logic [31:0]        w_cnpc;
  logic [1:0]         ctr_d;

  // The carried-down prediction bit is implied by ex_pred_npc; it is accepted
  // for pipeline symmetry only.
  logic               w_unused;
  assign w_unused = ex_pred_taken;

  // IF-stage lookup (reads pre-update contents, no bypass from EX)
  assign w_if_idx   = pc_if[IDX_W+1:2];
  assign w_if_tag   = pc_if[31:IDX_W+2];
  assign w_if_hit   = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);
  assign w_if_seq   = pc_if + 32'd4;
  assign pred_taken = w_if_hit & ctr_q[w_if_idx][1];
  assign npc_pred   = pred_taken ? target_q[w_if_idx] : w_if_seq;

  // EX-stage resolution
  assign w_ex_idx    = ex_pc[IDX_W+1:2];
  assign w_ex_tag    = ex_pc[31:IDX_W+2];
  assign w_ex_hit    = valid_q[w_ex_idx] && (tag_q[w_ex_idx] == w_ex_tag);
  assign w_upd       = ex_valid & ex_is_br;
  assign w_write     = w_upd & (w_ex_hit | ex_br);
  assign w_cnpc      = ex_br ? ex_target : (ex_pc + 32'd4);
  assign mispredict  = w_upd & (ex_pred_npc != w_cnpc);
  assign redirect_pc = w_cnpc;

  // Next counter value: saturating step on a hit, weakly-taken on allocation
  always_comb begin
    ctr_d = 2'b10;
    if (w_ex_hit) begin
      ctr_d = ctr_q[w_ex_idx];
      if (ex_br) begin
        if (ctr_q[w_ex_idx] != 2'b11) ctr_d = ctr_q[w_ex_idx] + 2'd1;
      end else begin
        if (ctr_q[w_ex_idx] != 2'b00) ctr_d = ctr_q[w_ex_idx] - 2'd1;
      end
    end
  end

  // Table update; reset clears every entry and overrides a concurrent update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (w_write) begin
      valid_q[w_ex_idx] <= 1'b1;
      tag_q[w_ex_idx]   <= w_ex_tag;
      ctr_q[w_ex_idx]   <= ctr_d;
      if (ex_br) target_q[w_ex_idx] <= ex_target;
    end
  end

`ifdef BRANCH_PREDICTOR_PERF_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Counter next-state: every resolved branch, and those that mispredicted
  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (w_upd) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (mispredict) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign br_cnt   = 32'h0;
  assign miss_cnt = 32'h0;
`endif

endmodule
`default_nettype wire
